hilo_mult_unit: RTL and testbench

Sequencing and HI/LO register stage wrapped around the team's combinational 32x32 unsigned array multiplier. It accepts MULT/MULTU requests from the execute stage and drives the multiplier operands. It holds them stable for a configurable multicycle settle window, then captures and sign-corrects the 64-bit product and writes it into the architectural HI/LO registers. It also serves MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

---
 rtl/hilo_pkg.sv | 25 ++
 rtl/hilo_regs.sv | 35 +++
 rtl/hilo_mult_unit.sv | 123 ++++++++++++
 tb/tb_hilo_mult_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and widths for the HI/LO multiply sequencer.
package hilo_pkg;

  localparam int unsigned WORD            = 32;
  localparam int unsigned DWORD           = 64;
  localparam int unsigned LATENCY_DEFAULT = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD-1:0] hi;
    logic [WORD-1:0] lo;
  } hilo_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, a valid unsigned magnitude.
  function automatic logic [WORD-1:0] magnitude(input logic [WORD-1:0] v, input logic sgn);
    return (sgn && v[WORD-1]) ? (~v + WORD'(1)) : v;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair; the multiply writeback wins over MTHI/MTLO.
module hilo_regs
  import hilo_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_wb_en,
  input  hilo_t           i_prod,
  input  logic            i_mthi,
  input  logic            i_mtlo,
  input  logic [WORD-1:0] i_wdata,
  output logic [WORD-1:0] o_hi,
  output logic [WORD-1:0] o_lo
);

  logic [WORD-1:0] r_hi;
  logic [WORD-1:0] r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_wb_en) begin
      r_hi <= i_prod.hi;
      r_lo <= i_prod.lo;
    end else begin
      if (i_mthi) r_hi <= i_wdata;
      if (i_mtlo) r_lo <= i_wdata;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/hilo_mult_unit.sv
// MULT/MULTU sequencer around an external unsigned multiplier, with HI/LO writeback.
// Signed MULT support is built only when MULT_SIGNED_EN is defined.
module hilo_mult_unit
  import hilo_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WORD-1:0]  rs_val,
  input  logic [WORD-1:0]  rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WORD-1:0]  wdata,
  output logic [WORD-1:0]  mul_a,
  output logic [WORD-1:0]  mul_b,
  input  logic [DWORD-1:0] mul_z,
  output logic             busy,
  output logic             done,
  output logic [WORD-1:0]  hi,
  output logic [WORD-1:0]  lo
);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_wb;
  logic [CNT_W-1:0] r_cnt;
  logic [WORD-1:0]  r_mul_a;
  logic [WORD-1:0]  r_mul_b;
  logic             r_busy;
  logic             r_done;
  logic             w_neg;
  logic             w_sgn;
  logic [DWORD-1:0] w_prod;
  logic             w_idle;

`ifdef MULT_SIGNED_EN
  logic r_neg;

  assign w_sgn  = op_signed;
  assign w_neg  = r_neg;
  assign w_prod = w_neg ? (~mul_z + DWORD'(1)) : mul_z;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_neg <= 1'b0;
    else if (w_load) r_neg <= w_sgn & (rs_val[WORD-1] ^ rt_val[WORD-1]);
  end
`else
  // Every request is MULTU; op_signed folds away to constant zero.
  assign w_sgn  = op_signed & 1'b0;
  assign w_neg  = 1'b0;
  assign w_prod = mul_z;
`endif

  // Next-state and control decode.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_wb   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = CALC;
          w_load = 1'b1;
        end
      end
      CALC: begin
        if (r_cnt == CNT_W'(LATENCY - 1)) w_next = WB;
      end
      WB: begin
        w_next = IDLE;
        w_wb   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, settle counter, operand and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == WB);
      if (w_load) begin
        r_cnt   <= '0;
        r_mul_a <= magnitude(rs_val, w_sgn);
        r_mul_b <= magnitude(rt_val, w_sgn);
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_idle = (r_state == IDLE);

  hilo_regs u_regs (
    .clk     (clk),
    .reset   (reset),
    .i_wb_en (w_wb),
    .i_prod  (hilo_t'(w_prod)),
    .i_mthi  (mthi & w_idle),
    .i_mtlo  (mtlo & w_idle),
    .i_wdata (wdata),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit at LATENCY = 2, with the multiplier modelled behaviourally.
module tb_hilo_mult_unit;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_signed;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  int n_done;

  always #5 clk = ~clk;

  assign mul_z = 64'(mul_a) * 64'(mul_b);

  hilo_mult_unit #(.LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_signed (op_signed),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check the full busy/done/result timeline.
  task automatic run_mul(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ema, input logic [31:0] emb,
                         input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    start = 1'b1; op_signed = sgn; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy1"}, 64'(busy), 64'd1);
    check({tag, " done1"}, 64'(done), 64'd0);
    check({tag, " mul_a"}, 64'(mul_a), 64'(ema));
    check({tag, " mul_b"}, 64'(mul_b), 64'(emb));
    @(negedge clk);
    check({tag, " busy2"}, 64'(busy), 64'd1);
    check({tag, " done2"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, " busy3"}, 64'(busy), 64'd1);
    check({tag, " done3"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, " busy4"}, 64'(busy), 64'd0);
    check({tag, " done4"}, 64'(done), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " mul_a hold"}, 64'(mul_a), 64'(ema));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_signed = 1'b0; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst mul_a", 64'(mul_a), 64'd0);
    check("rst mul_b", 64'(mul_b), 64'd0);
    reset = 1'b1;

    run_mul("multu ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001);

    if (SIGNED_EN) begin
      run_mul("mult -3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_mul("mult min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0000_0000);
      run_mul("mult min*1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1,
              32'hFFFF_FFFF, 32'h8000_0000);
      run_mul("mult -1*1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    end else begin
      run_mul("mult -3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
      run_mul("mult min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0000_0000);
      run_mul("mult min*1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1,
              32'h0000_0000, 32'h8000_0000);
      run_mul("mult -1*1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF);
    end

    // start and mthi while busy are dropped; exactly one done.
    n_done = 0;
    @(negedge clk);
    start = 1'b1; op_signed = 1'b0; rs_val = 32'd3; rt_val = 32'd7;
    @(negedge clk);
    rs_val = 32'd100; rt_val = 32'd200; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      if (done) n_done++;
      @(negedge clk);
      if (i == 0) check("busy ign mul_a", 64'(mul_a), 64'd3);
      if (i == 1) begin start = 1'b0; mthi = 1'b0; end
    end
    check("busy ign dones", 64'(n_done), 64'd1);
    check("busy ign hi", 64'(hi), 64'd0);
    check("busy ign lo", 64'(lo), 64'd21);
    check("busy ign idle", 64'(busy), 64'd0);

    // MTHI then MTLO in IDLE.
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi lo kept", 64'(lo), 64'd21);
    mtlo = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo hi kept", 64'(hi), 64'h1234_5678);

    // start with mthi in IDLE: mthi lands first, product overwrites later.
    mthi = 1'b1; wdata = 32'h0000_AAAA; start = 1'b1; op_signed = 1'b0; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    mthi = 1'b0; start = 1'b0;
    check("start+mthi hi", 64'(hi), 64'h0000_AAAA);
    repeat (3) @(negedge clk);
    check("start+mthi res hi", 64'(hi), 64'd0);
    check("start+mthi res lo", 64'(lo), 64'd6);

    // Async reset in CALC discards the multiply.
    start = 1'b1; rs_val = 32'd5; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("pre-rst busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    check("async rst mul_a", 64'(mul_a), 64'd0);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst no done", 64'(n_done), 64'd0);
    check("rst lo held", 64'(lo), 64'd0);

    run_mul("post-rst", 1'b0, 32'd6, 32'd7, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
